// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver with RX FIFO (optional parity via PARITY_EN)
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rx_en_i,
  input  logic [DIV_WIDTH-1:0]          baud_div_i,
  input  logic                          uart_rx_i,
  input  logic                          rd_en_i,
  input  logic                          err_clr_i,
  output logic [DATA_WIDTH-1:0]         rx_data_o,
  output logic                          rx_empty_o,
  output logic                          rx_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count_o,
  output logic                          frame_err_o,
`ifdef PARITY_EN
  input  logic                          parity_on_i,
  input  logic                          parity_odd_i,
  output logic                          parity_err_o,
`endif
  output logic                          overrun_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BI_W  = $clog2(DATA_WIDTH);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  logic                  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DIV_WIDTH-1:0]  tick_cnt_q, tick_cnt_d;
  logic [DIV_WIDTH-1:0]  div_last;
  logic                  tick;
  state_e                state_q, state_d;
  logic [3:0]            sc_q, sc_d;
  logic [BI_W-1:0]       bi_q, bi_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  line;
  logic                  push, ferr_set;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  fifo_full, fifo_empty, pop, do_push, overrun_set;
`ifdef PARITY_EN
  logic                  par_bad_q, par_bad_d;
  logic                  parity_err_q, parity_err_d;
  logic                  par_mismatch, perr_set;
  assign par_mismatch = line ^ (^shift_q) ^ parity_odd_i;
`endif

  assign sync1_d = uart_rx_i;
  assign sync2_d = sync1_q;
  assign line    = sync2_q;

  // State register, synchronizer, tick counter, flags and FIFO pointers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      tick_cnt_q  <= '0;
      state_q     <= S_IDLE;
      sc_q        <= '0;
      bi_q        <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      sc_q        <= sc_d;
      bi_q        <= bi_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // FIFO storage is deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (do_push) fifo_mem_q[wr_ptr_q] <= shift_q;
  end

  // Oversample tick: held at zero while idle on a high line so the first tick lands relative to the start edge
  always_comb begin
    div_last   = (baud_div_i > DIV_WIDTH'(1)) ? baud_div_i - DIV_WIDTH'(1) : '0;
    tick       = 1'b0;
    tick_cnt_d = tick_cnt_q + DIV_WIDTH'(1);
    if (!rx_en_i || (state_q == S_IDLE && line)) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q >= div_last) begin
      tick       = 1'b1;
      tick_cnt_d = '0;
    end
  end

  // Next-state logic: frame sequencing, sample counter, bit index and shift register
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bi_d    = bi_q;
    shift_d = shift_q;
`ifdef PARITY_EN
    par_bad_d = par_bad_q;
`endif
    if (!rx_en_i) begin
      state_d = S_IDLE;
    end else if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!line) begin
            state_d = S_START;
            sc_d    = '0;
          end
        end
        S_START: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd7) begin
            if (!line) begin
              state_d = S_DATA;
              sc_d    = '0;
              bi_d    = '0;
`ifdef PARITY_EN
              par_bad_d = 1'b0;
`endif
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            shift_d = {line, shift_q[DATA_WIDTH-1:1]};
            bi_d    = bi_q + BI_W'(1);
            if (bi_q == BI_LAST) begin
`ifdef PARITY_EN
              state_d = parity_on_i ? S_PARITY : S_STOP;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
        S_PARITY: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
`ifdef PARITY_EN
            if (par_mismatch) par_bad_d = 1'b1;
`endif
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode: stop-bit verdict produces either a push or a framing error
  always_comb begin
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef PARITY_EN
    perr_set = rx_en_i && tick && state_q == S_PARITY && sc_q == 4'd15 && par_mismatch;
`endif
    if (rx_en_i && tick && state_q == S_STOP && sc_q == 4'd15) begin
      if (line) begin
`ifdef PARITY_EN
        push = !par_bad_q;
`else
        push = 1'b1;
`endif
      end else begin
        ferr_set = 1'b1;
      end
    end
  end

  // FIFO bookkeeping and sticky error flags; a set in the clear cycle wins
  always_comb begin
    fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty  = (count_q == '0);
    pop         = rd_en_i && !fifo_empty;
    do_push     = push && (!fifo_full || pop);
    overrun_set = push && fifo_full && !pop;
    wr_ptr_d    = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    frame_err_d = ferr_set    | (frame_err_q & ~err_clr_i);
    overrun_d   = overrun_set | (overrun_q & ~err_clr_i);
`ifdef PARITY_EN
    parity_err_d = perr_set | (parity_err_q & ~err_clr_i);
`endif
  end

  assign rx_data_o   = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
  assign rx_empty_o  = fifo_empty;
  assign rx_full_o   = fifo_full;
  assign rx_count_o  = count_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
`ifdef PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (default 8N1 build)
module tb_uart_rx;
  localparam int DW      = 8;
  localparam int FD      = 16;
  localparam int DIVW    = 16;
  localparam int CW      = $clog2(FD) + 1;
  localparam int BIT_CYC = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx_en = 1'b0;
  logic [DIVW-1:0] baud_div = 16'd4;
  logic            line = 1'b1;
  logic            rd_en = 1'b0;
  logic            err_clr = 1'b0;
  logic [DW-1:0]   rx_data;
  logic            rx_empty, rx_full, frame_err, overrun;
  logic [CW-1:0]   rx_count;
`ifdef PARITY_EN
  logic            parity_err;
`endif

  uart_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .DIV_WIDTH(DIVW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_en_i    (rx_en),
    .baud_div_i (baud_div),
    .uart_rx_i  (line),
    .rd_en_i    (rd_en),
    .err_clr_i  (err_clr),
    .rx_data_o  (rx_data),
    .rx_empty_o (rx_empty),
    .rx_full_o  (rx_full),
    .rx_count_o (rx_count),
    .frame_err_o(frame_err),
`ifdef PARITY_EN
    .parity_on_i (1'b0),
    .parity_odd_i(1'b0),
    .parity_err_o(parity_err),
`endif
    .overrun_o  (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] sb[$];

  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    logic          exp_ferr;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic stop);
    line = 1'b0;
    cyc(BIT_CYC);
    for (int i = 0; i < DW; i++) begin
      line = data[i];
      cyc(BIT_CYC);
    end
    line = stop;
    cyc(BIT_CYC);
    line = 1'b1;
    cyc(100);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic drain();
    logic [DW-1:0] exp;
    for (int k = 0; k < FD + 2; k++) begin
      if (rx_empty) break;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h with empty scoreboard", rx_data);
        pop_one();
      end else begin
        exp = sb.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, exp});
        pop_one();
      end
    end
    check("sb_left", sb.size(), 0);
    check("empty_after_drain", {31'd0, rx_empty}, 1);
    check("data_zero_when_empty", {24'd0, rx_data}, 0);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b1};
    vecs[5] = '{8'h81, 1'b1, 1'b0};

    rst_n = 1'b0;
    cyc(10);
    check("rst_empty", {31'd0, rx_empty}, 1);
    check("rst_full", {31'd0, rx_full}, 0);
    check("rst_count", {27'd0, rx_count}, 0);
    check("rst_data", {24'd0, rx_data}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    check("rst_ovr", {31'd0, overrun}, 0);
    rst_n = 1'b1;
    rx_en = 1'b1;
    cyc(5);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop);
      if (vecs[v].stop) sb.push_back(vecs[v].data);
      check("vec_count", {27'd0, rx_count}, sb.size());
      check("vec_ferr", {31'd0, frame_err}, {31'd0, vecs[v].exp_ferr});
      drain();
      clear_errors();
      check("ferr_cleared", {31'd0, frame_err}, 0);
    end

    // false start: three ticks of low, then high
    line = 1'b0;
    cyc(12);
    line = 1'b1;
    cyc(200);
    check("fs_count", {27'd0, rx_count}, 0);
    check("fs_ferr", {31'd0, frame_err}, 0);
    send_frame(8'h3C, 1'b1);
    sb.push_back(8'h3C);
    check("fs_next_count", {27'd0, rx_count}, 1);
    drain();

    // pop while empty is ignored
    pop_one();
    check("pop_empty_count", {27'd0, rx_count}, 0);

    // overrun: 17 frames, the last one dropped
    for (int v = 0; v < FD + 1; v++) begin
      send_frame(8'(v), 1'b1);
      if (v < FD) sb.push_back(8'(v));
    end
    check("ovr_full", {31'd0, rx_full}, 1);
    check("ovr_count", {27'd0, rx_count}, FD);
    check("ovr_flag", {31'd0, overrun}, 1);
    check("ovr_ferr", {31'd0, frame_err}, 0);
    drain();
    check("ovr_sticky", {31'd0, overrun}, 1);
    clear_errors();
    check("ovr_cleared", {31'd0, overrun}, 0);

    // disable mid-frame during bit 3 of 0xFF
    line = 1'b0;
    cyc(BIT_CYC);
    line = 1'b1;
    cyc(BIT_CYC * 3 + 32);
    rx_en = 1'b0;
    cyc(600);
    rx_en = 1'b1;
    cyc(10);
    check("dis_count", {27'd0, rx_count}, 0);
    check("dis_ferr", {31'd0, frame_err}, 0);
    send_frame(8'h5A, 1'b1);
    sb.push_back(8'h5A);
    check("dis_next_count", {27'd0, rx_count}, 1);
    check("dis_next_data", {24'd0, rx_data}, 32'h5A);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Standalone UART receiver with 16x oversampling and a receive FIFO. It is the receiving end of the 8-bit, LSB-first, 1-start/1-stop serial frame produced by the UART transmitter. It sits between the uart_rx_i pad and the register interface, which sets baud_div_i and reads and pops received bytes.

Parameters:
DATA_WIDTH, 8, data bits per frame.
FIFO_DEPTH, 16, RX FIFO entries (power of 2, >=2).
DIV_WIDTH, 16, width of baud divisor.

Ports:
clk_i  input  1  system clock
rst_ni  input  1  synchronous active-low reset
rx_en_i  input  1  receiver enable
baud_div_i  input  DIV_WIDTH  clk_i cycles per 16x oversample tick
uart_rx_i  input  1  asynchronous serial line, idle high
rd_en_i  input  1  pop one byte from the FIFO head
err_clr_i  input  1  clear sticky error flags
rx_data_o  output  DATA_WIDTH  FIFO head (first-word-fall-through)
rx_empty_o  output  1  FIFO empty
rx_full_o  output  1  FIFO full
rx_count_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
frame_err_o  output  1  sticky: stop bit sampled low
overrun_o  output  1  sticky: byte dropped because the FIFO was full

Behaviour:
- Reset (rst_ni low at clk_i edge) sets:
  - rx_empty_o=1, rx_full_o=0, rx_count_o=0, rx_data_o=0, frame_err_o=0, overrun_o=0.
  - FSM=IDLE, tick counter=0, FIFO pointers=0, synchronizer flops=1.
  - FIFO storage is not reset.
- Synchronizer: uart_rx_i passes through 2 flops. All sampling uses the synchronized value.
- Tick generator:
  - Counter runs 0..baud_div_i-1 and emits a 1-cycle tick on wrap.
  - baud_div_i of 0 or 1 gives a tick every cycle.
  - Counter resets to 0 whenever FSM is IDLE and the line is high, so start timing aligns to the falling edge.
- FSM, with a 4-bit tick counter (sc) and a bit index (bi):
  - IDLE: on a tick with line low, go to START with sc=0.
  - START: at sc==7 (mid start bit), if the line is still low go to DATA with sc=0, bi=0. Otherwise go back to IDLE (false start, no error).
  - DATA: at sc==15, shift the line into the MSB of the shift register (LSB-first). Once bi reaches DATA_WIDTH-1, go to STOP.
  - STOP: at sc==15, sample the line, then go to IDLE.
    - Line 1: push the byte to the FIFO.
    - Line 0: set frame_err_o and discard the byte.
- rx_en_i low: FSM is forced to IDLE the next cycle and any partial frame is discarded. FIFO contents and flags are retained. rd_en_i still works.
- FIFO:
  - Push happens on the STOP-sample cycle. rx_empty_o drops and rx_data_o is valid on the following cycle.
  - rd_en_i with the FIFO non-empty pops the head; the new head appears next cycle. rd_en_i when empty is ignored.
  - rx_data_o reads 0 while empty.
  - Pointers wrap modulo FIFO_DEPTH. rx_count_o runs 0..FIFO_DEPTH.
  - Push while full and no pop: the byte is dropped and overrun_o is set. FIFO contents are unchanged.
  - Push + pop while full: both occur, count stays FIFO_DEPTH, no overrun.
  - Push + pop while empty: the pop is ignored and the push occurs (count goes to 1).
- Errors:
  - err_clr_i clears frame_err_o and overrun_o next cycle.
  - A set event in the same cycle as err_clr_i wins (the flag stays 1).

Optional Feature:
PARITY_EN
- Defined:
  - Adds input ports parity_on_i (1) and parity_odd_i (1, 1=odd parity), and output port parity_err_o (sticky, reset 0, cleared by err_clr_i).
  - When parity_on_i=1, a PARITY state sits between DATA and STOP. It samples at sc==15 and compares against the XOR of the data bits (inverted when parity_odd_i=1).
  - On mismatch, parity_err_o is set and the byte is discarded at STOP regardless of the stop bit.
- Undefined: ports absent, frames are 8N1 only.

Test Plan:
- Reset: hold rst_ni low for 10 cycles -> rx_empty_o=1, rx_count_o=0, rx_data_o=0x00, both error flags 0.
- baud_div_i=4, rx_en_i=1, drive 8N1 frame 0xA5 at 64 cycles/bit -> rx_count_o=1, rx_data_o=0xA5. Pulse rd_en_i -> rx_empty_o=1 next cycle.
- Line low for 3 ticks (12 cycles) then high -> no push, frame_err_o=0, FSM returns to IDLE. A following 0x3C frame is received correctly.
- Frame 0x3C with stop bit 0 -> frame_err_o=1, rx_empty_o=1. Pulse err_clr_i -> frame_err_o=0.
- 17 frames 0x00..0x10 with no reads -> rx_full_o=1, rx_count_o=16, overrun_o=1. Popping yields 0x00..0x0F in order, then rx_empty_o=1.
- Drop rx_en_i during bit 3 of 0xFF -> no push, no error. Re-enable, send 0x5A -> rx_data_o=0x5A, rx_count_o=1.
